// File: rtl/sliding_detector_seq.sv
// -----------------------------------------------------------------------------
// sliding_detector_seq
//
// Purpose:
//   This sequencer sits around one sliding-detector datapath in the RX DSP back
//   end. It builds the two-frame window {newer, older} from a stream of
//   width-wide frames and presents it to the external detector. It takes the
//   detector's per-position decision back, turns it into a flip mask for the
//   older frame and emits the corrected frame on a valid/ready output.
//   A flip that lands one bit past the top of a frame is carried into bit 0 of
//   the next emitted frame.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   in_valid/in_ready    input frame handshake
//   in_err, in_bits      residual error frame and sliced bit frame
//   flush                pulse: drain the held frame, with the newer half of
//                        the window zero-filled
//   bypass               emit bits uncorrected (sampled per emitted frame)
//   det_err, det_bits    window to the detector: [width-1:0] older frame,
//                        [2*width-1:width] newer frame
//   det_pos              detector decision per position; it is combinational
//                        from det_err/det_bits
//   out_valid/out_ready  corrected frame handshake
//   out_bits             corrected older frame
//   flip_count           saturating count of bits flipped
//   frame_count          saturating count of frames emitted
//
// Configuration:
//   SLIDING_DETECTOR_STATS_EN  When defined, the statistics counters are built.
//                              When not defined, flip_count and frame_count
//                              are tied to zero.
// -----------------------------------------------------------------------------
module sliding_detector_seq #(
  parameter int width              = 16,
  parameter int est_error_bitwidth = 8,
  parameter int cnt_bitwidth       = 16
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                in_valid,
  output logic                                                in_ready,
  input  logic signed [width-1:0][est_error_bitwidth-1:0]     in_err,
  input  logic        [width-1:0]                             in_bits,
  input  logic                                                flush,
  input  logic                                                bypass,
  output logic signed [2*width-1:0][est_error_bitwidth-1:0]   det_err,
  output logic        [2*width-1:0]                           det_bits,
  input  logic        [width-1:0][1:0]                        det_pos,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic        [width-1:0]                             out_bits,
  output logic        [cnt_bitwidth-1:0]                      flip_count,
  output logic        [cnt_bitwidth-1:0]                      frame_count
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, FLUSH} state_t;

  state_t                                    state_q;
  logic                                      o_valid_q;
  logic [width-1:0][est_error_bitwidth-1:0]  o_err_q;
  logic [width-1:0]                          o_bits_q;
  logic                                      carry_q;
  logic                                      out_valid_q;
  logic [width-1:0]                          out_bits_q;

  logic             holding;
  logic             flush_evt;
  logic             slot_free;
  logic             accept;
  logic             newer_live;
  logic             emit_run;
  logic             emit_flush;
  logic             emit;
  logic [width-1:0] flip_lo;
  logic [width-1:0] flip_hi;
  logic [width:0]   mask;
  logic [width-1:0] applied;
  logic [width-1:0] corrected;

  // O is valid in PRIME and RUN. The two states behave identically on the
  // next accept, because every accept that finds a valid O produces an emit.
  assign holding   = (state_q == PRIME) || (state_q == RUN);
  // Flush has priority over input in the same cycle.
  assign flush_evt = flush && holding;
  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (state_q != FLUSH) && slot_free && !flush_evt;
  assign accept    = in_valid && in_ready;

  // The newer slot is the incoming frame itself. It lands in O on the same
  // edge that emits the old O, so no separate N register is needed.
  // The newer slot is zero when no frame is offered, or when flushing.
  assign newer_live = holding && in_valid && !flush;

  assign det_err[width-1:0]         = o_valid_q  ? o_err_q  : '0;
  assign det_err[2*width-1:width]   = newer_live ? in_err   : '0;
  assign det_bits[width-1:0]        = o_valid_q  ? o_bits_q : '0;
  assign det_bits[2*width-1:width]  = newer_live ? in_bits  : '0;

  // Decode each position: bit 0 of det_pos flips bit i, and bit 1 flips
  // bit i+1.
  generate
    for (genvar gi = 0; gi < width; gi++) begin : g_pos
      assign flip_lo[gi] = det_pos[gi][0];
      assign flip_hi[gi] = det_pos[gi][1];
    end
  endgenerate

  // mask[width] is the flip that falls past the top of the frame.
  assign mask      = {1'b0, flip_lo} | {flip_hi, 1'b0};
  // The carry from the previous frame combines with this frame's own bit-0
  // flip.
  assign applied   = mask[width-1:0] ^ {{(width-1){1'b0}}, carry_q};
  assign corrected = o_bits_q ^ applied;

  assign emit_run   = accept && o_valid_q;
  assign emit_flush = slot_free && o_valid_q && (flush_evt || (state_q == FLUSH));
  assign emit       = emit_run || emit_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      o_valid_q   <= 1'b0;
      o_err_q     <= '0;
      o_bits_q    <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_bits_q  <= '0;
    end else begin
      if (emit) begin
        out_valid_q <= 1'b1;
        out_bits_q  <= bypass ? o_bits_q : corrected;
        // The carry out of a flushed frame has no successor, so it is dropped.
        carry_q     <= (bypass || emit_flush) ? 1'b0 : mask[width];
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (accept) begin
            o_err_q   <= in_err;
            o_bits_q  <= in_bits;
            o_valid_q <= 1'b1;
            state_q   <= PRIME;
          end
        end
        PRIME, RUN: begin
          if (flush_evt) begin
            // If the output is stalled, the drain finishes from FLUSH.
            state_q <= FLUSH;
            if (emit_flush) o_valid_q <= 1'b0;
          end else if (accept) begin
            o_err_q  <= in_err;
            o_bits_q <= in_bits;
            state_q  <= RUN;
          end
        end
        FLUSH: begin
          if (emit_flush) begin
            o_valid_q <= 1'b0;
          end else if (!o_valid_q && slot_free) begin
            state_q <= IDLE;
            carry_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_bits  = out_bits_q;

`ifdef SLIDING_DETECTOR_STATS_EN
  localparam int PW = $clog2(width + 1);
  localparam int SW = ((cnt_bitwidth > PW) ? cnt_bitwidth : PW) + 1;
  localparam logic [cnt_bitwidth-1:0] CNT_MAX = {cnt_bitwidth{1'b1}};

  logic [PW-1:0]           pop;
  logic [SW-1:0]           flip_sum;
  logic [cnt_bitwidth-1:0] flip_q;
  logic [cnt_bitwidth-1:0] frame_q;

  always_comb begin
    pop = '0;
    for (int i = 0; i < width; i++) begin
      pop = pop + PW'(applied[i]);
    end
  end

  assign flip_sum = SW'(flip_q) + SW'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flip_q  <= '0;
      frame_q <= '0;
    end else if (emit) begin
      if (frame_q != CNT_MAX) frame_q <= frame_q + 1'b1;
      if (!bypass) begin
        flip_q <= (flip_sum > SW'(CNT_MAX)) ? CNT_MAX : flip_sum[cnt_bitwidth-1:0];
      end
    end
  end

  assign flip_count  = flip_q;
  assign frame_count = frame_q;
`else
  assign flip_count  = '0;
  assign frame_count = '0;
`endif

endmodule

// File: doc/sliding_detector_seq.md
# sliding_detector_seq

Sequencer wrapping one sliding-detector datapath instance in the RX DSP back end. It builds the two-frame error/bit window the detector evaluates from a stream of width-wide frames, captures the detector's per-position decision and applies the resulting bit flips. It emits corrected frames through a valid/ready handshake and handles the frame-boundary carry, priming and end-of-stream flush.

## Interface
- width, 16, bits per frame (detector width)
- est_error_bitwidth, 8, signed residual error sample width
- cnt_bitwidth, 16, width of statistics counters
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input frame present
- in_ready  output  1  input frame accepted when in_valid&&in_ready
- in_err  input  signed est_error_bitwidth x [width]  residual error frame
- in_bits  input  1 x [width]  sliced bit frame
- flush  input  1  single-cycle pulse: drain the held frame
- bypass  input  1  pass bits uncorrected (level, sampled per output frame)
- det_err  output  signed est_error_bitwidth x [2*width]  window to detector; [width-1:0] older frame, [2*width-1:width] newer frame
- det_bits  output  1 x [2*width]  same layout for bits
- det_pos  input  2 x [width]  detector decision, combinational from det_err/det_bits
- out_valid  output  1  corrected frame present
- out_ready  input  1  downstream accepts
- out_bits  output  1 x [width]  corrected older frame
- flip_count  output  cnt_bitwidth  total bits flipped, saturating
- frame_count  output  cnt_bitwidth  frames emitted, saturating

## Operation
- Registers: older frame O (err, bits), newer frame N, carry bit C, output register.
- det_err/det_bits driven directly from {N, O}; zero when the corresponding slot is empty.
- FSM states: IDLE (no frame), PRIME (O valid, N empty), RUN (O and N valid), FLUSH (draining O with N zero-filled).
- IDLE: accept -> frame into O, go PRIME.
- PRIME: accept -> frame into N; the same edge evaluates window {N_in, O}. Effective rule: an emit happens on every accept while O is valid; O <- N_in after emit; stay RUN.
- RUN: accept -> emit corrected O, O <- incoming, stay RUN.
- flush in PRIME or RUN (no simultaneous accept; flush takes priority and in_ready=0 that cycle): evaluate window with N zero, emit O, go FLUSH then IDLE once the output is taken. flush in IDLE ignored.
- Decision mapping per position i: pos 0 none; pos 1 flip bit i; pos 2 flip bit i+1; pos 3 flip bits i and i+1. Flip mask is the OR over all positions. Mask bit width (i+1 at i=width-1) is stored into C and XORed into bit 0 of the next emitted frame. C is cleared on FLUSH exit; carry out of the flushed frame is discarded.
- C also XORs into the emitted frame's bit 0 together with that frame's own mask bit 0.
- bypass=1: out_bits = O bits unmodified, C not updated (cleared), flip_count unchanged.
- flip_count += popcount(applied mask, including C) per emitted frame; frame_count += 1; both saturate at all-ones.

## Timing
- Reset: state IDLE, O/N/C cleared, out_valid=0, out_bits=0, counters 0, in_ready=1.
- in_ready = (state!=FLUSH) && (!out_valid || out_ready).
- Latency: frame k appears on out_bits the cycle after frame k+1 (or flush) is accepted.
- Output register holds while out_valid && !out_ready; accepts and emits on the same edge are allowed (full throughput, one frame/cycle).
- Detector path is combinational within one cycle; no internal pipeline stages.
- Reset mid-operation discards all held frames and carry immediately.

## Configuration
- SLIDING_DETECTOR_STATS_EN defined: flip_count and frame_count implemented as above.
- Not defined: counters and popcount logic absent; flip_count and frame_count tied to 0.

## Test plan
- Reset then frames A,B with det_pos all 0, out_ready=1 -> out_valid one cycle after B accepted, out_bits=A bits, frame_count=1.
- det_pos[3]=1 on frame A (width 16) -> out_bits = A with bit 3 inverted; flip_count=1.
- det_pos[15]=2 on A -> A emitted unchanged; next frame B emitted with bit 0 inverted; flip_count=1.
- out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_bits stable; on release one frame per cycle resumes, no frame lost or duplicated.
- PRIME with frame A then flush -> A emitted with window upper half zero, state returns IDLE, C=0.
- bypass=1 with det_pos[5]=3 -> bits unmodified, flip_count unchanged; counters at all-ones stay saturated.
